// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the packet-aware FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {StIdle, StBusy} arb_state_e;

  localparam int unsigned MaxNreq = 16;
  localparam int unsigned IdxW    = $clog2(MaxNreq);

  function automatic logic [MaxNreq-1:0] onehot(input logic [IdxW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: returns the first set request at or after i_base, modulo NREQ.
module rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_base,
  output logic            o_any,
  output logic [IW-1:0]   o_idx
);

  int          w_j;
  logic [IW-1:0] w_pos;

  // Scan from the farthest offset down so the nearest request is written last and wins.
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    w_j   = 0;
    w_pos = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      w_j = int'(i_base) + k;
      if (w_j >= int'(NREQ)) w_j = w_j - int'(NREQ);
      w_pos = IW'(w_j);
      if (i_req[w_pos]) o_idx = w_pos;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter for the FIFO write port; owner holds the port until its last word.
// Optional per-requester accepted-word counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       last,
  input  logic [NREQ*DSIZE-1:0] wdata_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  input  logic                  fifo_full,
  output logic                  fifo_wreq,
  output logic [DSIZE-1:0]      fifo_wdata
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*CNTW-1:0]  word_cnt
`endif
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       r_state;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_rr_ptr;
  logic [NREQ-1:0]  r_gnt;

  logic             w_any;
  logic [IW-1:0]    w_idx;
  logic             w_accept;
  logic [MaxNreq-1:0] w_oh;
  logic             w_unused_oh;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .i_req  (req),
    .i_base (r_rr_ptr),
    .o_any  (w_any),
    .o_idx  (w_idx)
  );

  assign w_oh        = onehot(IdxW'(w_idx));
  assign w_unused_oh = ^w_oh;
  assign gnt         = r_gnt;

  always_comb begin
    fifo_wreq  = 1'b0;
    ack        = '0;
    w_accept   = 1'b0;
    fifo_wdata = wdata_in[int'(r_owner)*DSIZE +: DSIZE];
    if (r_state == StBusy) begin
      fifo_wreq    = req[r_owner];
      w_accept     = req[r_owner] & ~fifo_full;
      ack[r_owner] = w_accept;
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_owner <= w_idx;
            r_gnt   <= w_oh[NREQ-1:0];
            r_state <= StBusy;
          end
        end
        StBusy: begin
          if (w_accept && last[r_owner]) begin
            r_state  <= StIdle;
            r_gnt    <= '0;
            r_rr_ptr <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < int'(NREQ); g++) begin : g_cnt
    logic [CNTW-1:0] r_cnt;

    always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (ack[g] && (r_cnt != {CNTW{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign word_cnt[g*CNTW +: CNTW] = r_cnt;
  end
`else
  logic w_unused_cntw;
  assign w_unused_cntw = ^CNTW;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized self-checking bench for fifo_wr_arbiter against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;

  localparam int N    = 4;
  localparam int D    = 8;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic           wclk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, last, gnt, ack;
  logic [N*D-1:0] wdata_in;
  logic           fifo_full, fifo_wreq;
  logic [D-1:0]   fifo_wdata;
`ifdef FIFO_ARB_STATS_EN
  logic [N*CNTW-1:0] word_cnt;
`endif

  fifo_wr_arbiter #(
    .NREQ  (N),
    .DSIZE (D),
    .CNTW  (CNTW)
  ) dut (
    .wclk       (wclk),
    .rst_n      (rst_n),
    .req        (req),
    .last       (last),
    .wdata_in   (wdata_in),
    .gnt        (gnt),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_wreq  (fifo_wreq),
    .fifo_wdata (fifo_wdata)
`ifdef FIFO_ARB_STATS_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester-side state: words left in the current packet, sequence number, request held.
  int       rem  [N];
  logic [5:0] seq [N];
  logic     rq   [N];
  int       full_left;

  // Model: -1 means no owner; rr pointer and saturating counters.
  int m_owner, m_ptr;
  int m_cnt [N];
  int open_pkt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_stats();
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) check($sformatf("word_cnt%0d", i), 32'(word_cnt[i*CNTW +: CNTW]),
                                      32'(m_cnt[i]));
`endif
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
    for (int d = 0; d < N; d++) if (r[(m_ptr + d) % N]) return (m_ptr + d) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    open_pkt = -1;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      rem[i]   = 0;
      rq[i]    = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge wclk);
    rst_n = 1'b0;
    req   = '1;
    last  = '0;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_wreq", 32'(fifo_wreq), 0);
    model_reset();
    repeat (2) @(negedge wclk);
    #1;
    check("rst_hold_gnt", 32'(gnt), 0);
    check_stats();
    @(posedge wclk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cycle(input int phase);
    logic [N-1:0] eg, ea;
    logic         ew;
    int           o, id;
    @(negedge wclk);
    if (phase == 1) begin
      if (full_left == 0 && $urandom_range(7) == 0) full_left = $urandom_range(5, 1);
      fifo_full = (full_left > 0);
      if (full_left > 0) full_left--;
    end else begin
      fifo_full = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0 && (phase != 2 || i == 3)) rem[i] = (phase == 0) ? 1 : $urandom_range(4, 1);
      if (rem[i] > 0 && !rq[i]) rq[i] = (phase == 1) ? ($urandom_range(3) != 0) : 1'b1;
      req[i]            = rq[i];
      last[i]           = (rem[i] == 1);
      wdata_in[i*D +: D] = {2'(i), seq[i]};
    end
    #1;
    o  = m_owner;
    eg = (o >= 0) ? N'(1 << o) : '0;
    ew = (o >= 0) ? req[o] : 1'b0;
    ea = (o >= 0 && req[o] && !fifo_full) ? N'(1 << o) : '0;
    check("gnt", 32'(gnt), 32'(eg));
    check("ack", 32'(ack), 32'(ea));
    check("wreq", 32'(fifo_wreq), 32'(ew));
    if (ew) check("wdata", 32'(fifo_wdata), 32'(wdata_in[o*D +: D]));
    // Packets must land in the FIFO contiguously, whatever the arbiter state says.
    if (fifo_wreq && !fifo_full) begin
      id = int'(fifo_wdata[7:6]);
      if (open_pkt >= 0) check("pkt_lock", 32'(id), 32'(open_pkt));
      open_pkt = last[id] ? -1 : id;
    end
    if (o < 0) begin
      m_owner = model_pick(req);
    end else if (req[o] && !fifo_full) begin
      if (m_cnt[o] < CMAX) m_cnt[o]++;
      if (last[o]) begin
        m_ptr   = (o + 1) % N;
        m_owner = -1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i] && rem[i] > 0) begin
        rem[i]--;
        seq[i]++;
        rq[i] = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '1;
    last      = '0;
    wdata_in  = '0;
    fifo_full = 1'b0;
    full_left = 0;
    for (int i = 0; i < N; i++) seq[i] = 6'(i * 16);
    model_reset();
    do_reset();
    repeat (40) cycle(0);
    check_stats();
    repeat (700) cycle(1);
    do_reset();
    repeat (800) cycle(1);
    check_stats();
    do_reset();
    repeat (80) cycle(2);
    check_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Packet-aware round-robin arbiter sharing the single write port of the asynchronous FIFO among NREQ requesters in the write clock domain. A granted requester owns the port until its last word is accepted, so packets never interleave in the FIFO. It drives the FIFO's wreq/wdata and observes its registered full flag; it runs entirely on wclk.

## Interface
- NREQ, 4: number of requesters (2..16)
- DSIZE, 8: data width, equal to the FIFO's DSIZE
- CNTW, 16: width of each statistics counter (FIFO_ARB_STATS_EN only)

Ports:
- wclk  in  1  write-domain clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester word valid
- last  in  NREQ  per-requester end-of-packet flag, qualifies the current word
- wdata_in  in  NREQ*DSIZE  requester i data in bits [i*DSIZE +: DSIZE]
- gnt  out  NREQ  one-hot registered owner indication, 0 when idle
- ack  out  NREQ  one-hot word-accepted strobe, combinational
- fifo_full  in  1  FIFO full flag
- fifo_wreq  out  1  FIFO write request
- fifo_wdata  out  DSIZE  FIFO write data
- word_cnt  out  NREQ*CNTW  accepted-word counters (FIFO_ARB_STATS_EN only)

## Operation
- States: IDLE, BUSY. Registers: state, owner (log2 NREQ bits), rr_ptr (log2 NREQ bits).
- IDLE: if any req, pick the first set req[i] scanning i = rr_ptr, rr_ptr+1, … modulo NREQ. On the next edge: owner <= i, gnt <= onehot(i), state <= BUSY. Nothing is written in IDLE; fifo_wreq = 0, ack = 0.
- BUSY:
  - fifo_wreq = req[owner]
  - fifo_wdata = wdata_in[owner]
  - ack[owner] = req[owner] & ~fifo_full; all other ack bits are 0.
  - A word is accepted at the edge where ack[owner] = 1. The FIFO writes it on the same edge.
- Accepted word with last[owner] = 1: on that edge state <= IDLE, gnt <= 0, rr_ptr <= (owner+1) mod NREQ.
- Requester rule: hold req, data and last stable until ack. Deasserting req mid-packet is legal. The arbiter stays in BUSY with the same owner, and no other requester is granted.
- fifo_full high: ack held low, and the word stays on fifo_wdata. No state change.
- Non-owner req changes during BUSY have no effect.
- Reset values: state IDLE, owner 0, rr_ptr 0, gnt 0, ack 0, fifo_wreq 0, word_cnt 0.

## Timing
- Grant latency: req rising in IDLE leads to gnt on the next edge; the first word can be accepted at the following edge (2 edges after req).
- Throughput:
  - Within a packet: 1 word/cycle while fifo_full is low.
  - Between packets: one IDLE bubble cycle, so single-word packets from all requesters sustain 1 word per 2 cycles.
- Ack, fifo_wreq and fifo_wdata are combinational from registered state plus req, data and fifo_full. There is no extra latency to the FIFO.
- Simultaneous requests in IDLE are resolved by rr_ptr only; lower index wins ties at the same distance.
- Reset mid-packet clears ownership immediately (asynchronous). The partial packet already in the FIFO is left as is.

## Configuration
- FIFO_ARB_STATS_EN defined:
  - word_cnt port present.
  - Counter i increments on each edge where ack[i] = 1 and saturates at 2^CNTW-1.
  - Counters clear only on rst_n.
- Not defined: word_cnt port and counters absent. Arbitration behaviour is identical.

## Structure
- Package fifo_arb_pkg: state enum (IDLE, BUSY), localparam for the owner index width, and an onehot(index) function.
- Sub-module rr_picker: combinational rotating-priority encoder. Inputs are req and base; outputs are any and idx. It is instantiated once.
- Statistics counters stay in the top level, inside the macro guard.

## Test plan
- Reset: rst_n low with req = 4'b1111 gives gnt = 0, ack = 0, fifo_wreq = 0. After release, gnt = 4'b0001 one edge later.
- Fairness: all four requesters send 1-word packets continuously. Grant order is 0,1,2,3,0, one word every 2 cycles, with rr_ptr wrapping 3→0.
- Packet lock: requester 1 sends 3 words (last on word 3) while requester 2 requests. The FIFO receives 1a,1b,1c before any word from 2, and gnt goes from 4'b0010 to 0 to 4'b0100.
- Full stall: fifo_full high for 5 cycles mid-packet. ack stays 0, fifo_wdata holds, and no word is lost or duplicated after full drops.
- Mid-packet req drop: owner 0 deasserts req for 3 cycles before last. gnt stays 4'b0001 and no other ack occurs.
- Stats (FIFO_ARB_STATS_EN, CNTW = 4): 20 accepted words on requester 3 gives word_cnt[3] = 15 (saturated), while the other counters remain 0.
